// File: rtl/lock_clear.sv
// lock_clear
// ----------
// Sits behind the falling-piece stage. When a landed piece is reported, its
// occupancy grid is ORed into the persistent stack. The stack is then scanned
// bottom-up, one row per clock. Each full row is removed by shifting every row
// above it down by one. The number of rows removed is reported at the end.
//
// Grid layout: row r, column c lives at bit r*COLS + c of the flat vectors.
// Row 0 is the top of the well. Rows 0..1 are the hidden spawn rows.
//
// Optional feature: define SCORE_EN to build the running score accumulator.
// Without it, score is tied to zero.
//
// Ports
//   clk            system clock
//   rst            asynchronous active-high reset
//   lock_req       landed-piece strobe, only acted on while idle
//   piece_array    landed piece occupancy, held stable while busy
//   clear_stack    synchronous wipe of stack and status, wins over lock_req
//   stack_array    registered settled stack
//   busy           high whenever the block is not idle
//   done           one-cycle pulse at the end of a lock
//   lines_cleared  rows removed by the latest lock (saturates at 7)
//   lines_total    saturating running count of removed rows
//   game_over      sticky flag: merge overlap or spawn rows occupied
//   score          running score (zero unless SCORE_EN)
module lock_clear #(
  parameter int ROWS    = 22,
  parameter int COLS    = 10,
  parameter int TOTAL_W = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 lock_req,
  input  logic [ROWS*COLS-1:0] piece_array,
  input  logic                 clear_stack,
  output logic [ROWS*COLS-1:0] stack_array,
  output logic                 busy,
  output logic                 done,
  output logic [2:0]           lines_cleared,
  output logic [TOTAL_W-1:0]   lines_total,
  output logic                 game_over,
  output logic [19:0]          score
);

  localparam int                 RW        = $clog2(ROWS);
  localparam int                 N         = ROWS * COLS;
  localparam logic [RW-1:0]      LAST_ROW  = RW'(ROWS - 1);
  localparam logic [TOTAL_W-1:0] TOTAL_MAX = '1;

  typedef enum logic [1:0] {IDLE, MERGE, SCAN, DONE} state_t;

  state_t             state_q;
  logic [N-1:0]       stack_q;
  logic [RW-1:0]      rowPtr_q;
  logic               busy_q;
  logic               done_q;
  logic               gameOver_q;
  logic [2:0]         linesCleared_q;
  logic [TOTAL_W-1:0] linesTotal_q;

  logic [COLS-1:0]    curRow;
  logic               curRowFull;
  logic [N-1:0]       shiftStack_d;
  logic               overlap;
  logic               spawnOccupied;

  // Select the row currently addressed by the scan pointer.
  always_comb begin
    curRow = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (rowPtr_q == RW'(r)) begin
        curRow = stack_q[r*COLS +: COLS];
      end
    end
  end

  assign curRowFull = &curRow;

  // Stack with the scanned row removed. Rows 1..ptr take the row above them.
  // Row 0 becomes empty. Rows below the pointer are untouched.
  always_comb begin
    shiftStack_d = stack_q;
    for (int r = 0; r < ROWS; r++) begin
      if (r == 0) begin
        shiftStack_d[0 +: COLS] = '0;
      end else if (RW'(r) <= rowPtr_q) begin
        shiftStack_d[r*COLS +: COLS] = stack_q[(r-1)*COLS +: COLS];
      end
    end
  end

  assign overlap       = |(stack_q & piece_array);
  assign spawnOccupied = |stack_q[2*COLS-1:0];

  // Main sequencer. The pointer is held after a clear so that the row just
  // shifted into place is examined again before moving up.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      stack_q        <= '0;
      rowPtr_q       <= LAST_ROW;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      gameOver_q     <= 1'b0;
      linesCleared_q <= '0;
      linesTotal_q   <= '0;
    end else if (clear_stack) begin
      state_q        <= IDLE;
      stack_q        <= '0;
      rowPtr_q       <= LAST_ROW;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      gameOver_q     <= 1'b0;
      linesCleared_q <= '0;
      linesTotal_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (lock_req) begin
            state_q        <= MERGE;
            busy_q         <= 1'b1;
            linesCleared_q <= '0;
          end
        end
        MERGE: begin
          stack_q  <= stack_q | piece_array;
          rowPtr_q <= LAST_ROW;
          state_q  <= SCAN;
          if (overlap) begin
            gameOver_q <= 1'b1;
          end
        end
        SCAN: begin
          if (curRowFull) begin
            stack_q <= shiftStack_d;
            if (linesCleared_q != 3'd7) begin
              linesCleared_q <= linesCleared_q + 3'd1;
            end
            if (linesTotal_q != TOTAL_MAX) begin
              linesTotal_q <= linesTotal_q + TOTAL_W'(1);
            end
          end else if (rowPtr_q == '0) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            rowPtr_q <= rowPtr_q - RW'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          if (spawnOccupied) begin
            gameOver_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef SCORE_EN
  logic [19:0] score_q;
  logic [19:0] scoreInc;
  logic [20:0] scoreSum;

  // Points awarded for the lock that is finishing.
  always_comb begin
    case (linesCleared_q)
      3'd0:    scoreInc = 20'd0;
      3'd1:    scoreInc = 20'd40;
      3'd2:    scoreInc = 20'd100;
      3'd3:    scoreInc = 20'd300;
      default: scoreInc = 20'd1200;
    endcase
  end

  assign scoreSum = {1'b0, score_q} + {1'b0, scoreInc};

  // Accumulate once per lock, on the edge leaving DONE, saturating at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      score_q <= '0;
    end else if (clear_stack) begin
      score_q <= '0;
    end else if (state_q == DONE) begin
      score_q <= scoreSum[20] ? 20'hFFFFF : scoreSum[19:0];
    end
  end

  assign score = score_q;
`else
  assign score = '0;
`endif

  assign stack_array   = stack_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign lines_cleared = linesCleared_q;
  assign lines_total   = linesTotal_q;
  assign game_over     = gameOver_q;

endmodule

// File: tb/tb_lock_clear.sv
// tb_lock_clear
// -------------
// Testbench for lock_clear. Each lock predicts its outcome from an independent
// compaction model and pushes the prediction onto a scoreboard queue. The
// prediction is popped and compared when the DUT pulses done. Build with
// SCORE_EN defined to also check the score accumulator.
module tb_lock_clear;

  localparam int ROWS      = 22;
  localparam int COLS      = 10;
  localparam int TOTAL_W   = 10;
  localparam int N         = ROWS * COLS;
  localparam int TOTAL_LIM = (1 << TOTAL_W) - 1;
`ifdef SCORE_EN
  localparam bit SCORE_ON = 1'b1;
`else
  localparam bit SCORE_ON = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst;
  logic               lock_req;
  logic [N-1:0]       piece_array;
  logic               clear_stack;
  logic [N-1:0]       stack_array;
  logic               busy;
  logic               done;
  logic [2:0]         lines_cleared;
  logic [TOTAL_W-1:0] lines_total;
  logic               game_over;
  logic [19:0]        score;

  int passCount  = 0;
  int checkCount = 0;

  typedef struct {
    logic [N-1:0]       stack;
    logic [2:0]         lines;
    logic [TOTAL_W-1:0] total;
    logic               goMid;
    logic               go;
    logic [19:0]        score;
    int                 latency;
  } exp_t;

  exp_t sbQ[$];

  logic [N-1:0]       mStack;
  logic [TOTAL_W-1:0] mTotal;
  logic               mGo;
  logic [19:0]        mScore;

  lock_clear #(.ROWS(ROWS), .COLS(COLS), .TOTAL_W(TOTAL_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .lock_req      (lock_req),
    .piece_array   (piece_array),
    .clear_stack   (clear_stack),
    .stack_array   (stack_array),
    .busy          (busy),
    .done          (done),
    .lines_cleared (lines_cleared),
    .lines_total   (lines_total),
    .game_over     (game_over),
    .score         (score)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [N-1:0] colPiece(input int col, input int rLo, input int rHi);
    logic [N-1:0] v;
    v = '0;
    for (int r = rLo; r <= rHi; r++) v[r*COLS + col] = 1'b1;
    return v;
  endfunction

  function automatic logic [N-1:0] rowPiece(input int r, input logic [COLS-1:0] bits);
    logic [N-1:0] v;
    v = '0;
    v[r*COLS +: COLS] = bits;
    return v;
  endfunction

  function automatic int scoreFor(input logic [2:0] lines);
    case (lines)
      3'd0:    return 0;
      3'd1:    return 40;
      3'd2:    return 100;
      3'd3:    return 300;
      default: return 1200;
    endcase
  endfunction

  task automatic modelReset();
    mStack = '0;
    mTotal = '0;
    mGo    = 1'b0;
    mScore = '0;
  endtask

  // Predict a lock: merge, then drop full rows by packing survivors downward.
  task automatic pushExpected(input logic [N-1:0] piece);
    exp_t            e;
    logic [N-1:0]    s;
    logic [N-1:0]    ns;
    logic [COLS-1:0] row;
    int              dst;
    int              k;
    int              t;
    int              sc;
    e.goMid = mGo | (|(mStack & piece));
    s   = mStack | piece;
    ns  = '0;
    dst = ROWS - 1;
    k   = 0;
    for (int r = ROWS - 1; r >= 0; r--) begin
      row = s[r*COLS +: COLS];
      if (&row) begin
        k++;
      end else begin
        ns[dst*COLS +: COLS] = row;
        dst--;
      end
    end
    mStack  = ns;
    e.lines = (k > 7) ? 3'd7 : 3'(k);
    t       = int'(mTotal) + k;
    mTotal  = (t > TOTAL_LIM) ? TOTAL_W'(TOTAL_LIM) : TOTAL_W'(t);
    mGo     = e.goMid | (|ns[2*COLS-1:0]);
    sc      = int'(mScore) + scoreFor(e.lines);
    mScore  = (sc > 20'hFFFFF) ? 20'hFFFFF : 20'(sc);
    e.stack   = mStack;
    e.total   = mTotal;
    e.go      = mGo;
    e.score   = SCORE_ON ? mScore : 20'd0;
    e.latency = ROWS + 1 + k;
    sbQ.push_back(e);
  endtask

  // Drive one lock and compare the scoreboard entry when done appears.
  // pulseAt >= 0 re-asserts lock_req for one cycle that many edges in.
  task automatic applyStimulus(input logic [N-1:0] piece, input int pulseAt);
    exp_t e;
    int   n;
    int   busyCnt;
    bit   seen;
    pushExpected(piece);
    piece_array = piece;
    lock_req    = 1'b1;
    @(posedge clk); #1;
    lock_req = 1'b0;
    n        = 0;
    busyCnt  = 0;
    seen     = 1'b0;
    e        = sbQ.pop_front();
    while (!seen && n < 100) begin
      if (busy) busyCnt++;
      if (done) begin
        seen = 1'b1;
      end else begin
        if (n == pulseAt) lock_req = 1'b1;
        @(posedge clk); #1;
        lock_req = 1'b0;
        n++;
        if (n == 1) check("goAfterMerge", game_over, e.goMid);
      end
    end
    check("doneSeen", seen, 1'b1);
    if (seen) begin
      check("latency", n, e.latency);
      check("busyCycles", busyCnt, e.latency + 1);
      check("linesCleared", lines_cleared, e.lines);
      check("stack", stack_array, e.stack);
      check("linesTotal", lines_total, e.total);
      @(posedge clk); #1;
      check("doneFallBusyFall", {done, busy}, 2'b00);
      check("gameOver", game_over, e.go);
      check("score", score, e.score);
    end
  endtask

  task automatic clearStack();
    clear_stack = 1'b1;
    @(posedge clk); #1;
    clear_stack = 1'b0;
    modelReset();
  endtask

  task automatic checkOutput(input string prefix);
    check({prefix, ".stack"}, stack_array, '0);
    check({prefix, ".busy"}, busy, 1'b0);
    check({prefix, ".done"}, done, 1'b0);
    check({prefix, ".lines"}, lines_cleared, 3'd0);
    check({prefix, ".total"}, lines_total, '0);
    check({prefix, ".gameOver"}, game_over, 1'b0);
    check({prefix, ".score"}, score, 20'd0);
  endtask

  task automatic watchNoDone(input string tag, input int cycles);
    bit seen;
    seen = 1'b0;
    repeat (cycles) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    check(tag, seen, 1'b0);
  endtask

  initial begin
    logic [N-1:0] linePiece;
    logic [N-1:0] gapRows;
    logic [N-1:0] fullRows;

    rst         = 1'b1;
    lock_req    = 1'b0;
    clear_stack = 1'b0;
    piece_array = '0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Vertical line on an empty stack: no clears.
    linePiece = colPiece(4, 18, 21);
    applyStimulus(linePiece, -1);
    check("t1.stackConst", stack_array, linePiece);

    // Single clear: row 21 missing column 4 only.
    clearStack();
    applyStimulus(rowPiece(21, 10'b1111101111), -1);
    applyStimulus(linePiece, -1);
    check("t2.stackConst", stack_array, colPiece(4, 19, 21));
    check("t2.totalConst", lines_total, 1);
    check("t2.scoreConst", score, SCORE_ON ? 20'd40 : 20'd0);

    // Tetris: rows 18..21 missing column 4.
    clearStack();
    gapRows = '0;
    for (int r = 18; r <= 21; r++) gapRows |= rowPiece(r, 10'b1111101111);
    applyStimulus(gapRows, -1);
    applyStimulus(linePiece, -1);
    check("t3.linesConst", lines_cleared, 3'd4);
    check("t3.stackConst", stack_array, '0);
    check("t3.scoreConst", score, SCORE_ON ? 20'd1200 : 20'd0);

    // Overlap sets game_over at merge; sticky; clear_stack removes it.
    clearStack();
    applyStimulus(linePiece, -1);
    applyStimulus(linePiece, -1);
    applyStimulus(colPiece(0, 21, 21), -1);
    check("t4.goSticky", game_over, 1'b1);
    clearStack();
    check("t4.goCleared", game_over, 1'b0);

    // Piece resting in spawn row 1 flags game_over at DONE.
    applyStimulus(colPiece(0, 1, 1), -1);
    check("t4.goSpawn", game_over, 1'b1);
    clearStack();

    // Extra lock_req during SCAN is ignored.
    applyStimulus(linePiece, 8);
    watchNoDone("t5.noSecondDone", 40);

    // Reset in the middle of SCAN aborts with no done.
    piece_array = colPiece(7, 18, 21);
    lock_req    = 1'b1;
    @(posedge clk); #1;
    lock_req = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b1;
    #2;
    checkOutput("midReset");
    @(posedge clk); #1;
    rst = 1'b0;
    modelReset();
    watchNoDone("t5.noDoneAfterReset", 30);

    // clear_stack beats a simultaneous lock_req.
    applyStimulus(colPiece(2, 20, 21), -1);
    lock_req    = 1'b1;
    clear_stack = 1'b1;
    @(posedge clk); #1;
    lock_req    = 1'b0;
    clear_stack = 1'b0;
    modelReset();
    check("t6.lockDropped", busy, 1'b0);
    check("t6.stackWiped", stack_array, '0);

    // Saturation: each lock removes 20 rows.
    fullRows = '0;
    for (int r = 2; r < ROWS; r++) fullRows |= rowPiece(r, '1);
    applyStimulus(fullRows, -1);
    check("t7.linesSat", lines_cleared, 3'd7);
    for (int i = 0; i < 51; i++) applyStimulus(fullRows, -1);
    check("t7.totalAtMax", lines_total, TOTAL_LIM);
    applyStimulus(rowPiece(21, '1), -1);
    check("t7.totalHeld", lines_total, TOTAL_LIM);
    check("t7.linesOne", lines_cleared, 3'd1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
